// File: rtl/vec_writeback.sv
// vec_writeback: scratchpad owner and write-back sequencer for the vector unit.
// Holds the working memory, exposes it flat, and commits each latched result
// one word per cycle starting at the requested destination address.
// Optional feature macro: VEC_WRITEBACK_PENDING_EN (one-deep pending request).
module vec_writeback #(
  parameter int unsigned NUM_SIZE        = 16,
  parameter int unsigned VEC_BUFFER_LEN  = 8,
  parameter int unsigned WORDS_IN_MEMORY = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [VEC_BUFFER_LEN*NUM_SIZE-1:0]    flat_vec_buffer,
  input  logic                                  copy_req,
  input  logic [$clog2(WORDS_IN_MEMORY)-1:0]    dest,
  input  logic [$clog2(VEC_BUFFER_LEN)-1:0]     length,
  input  logic                                  host_we,
  input  logic [$clog2(WORDS_IN_MEMORY)-1:0]    host_addr,
  input  logic [NUM_SIZE-1:0]                   host_data,
  output logic                                  host_ready,
  output logic [WORDS_IN_MEMORY*NUM_SIZE-1:0]   flat_memory,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned AW = $clog2(WORDS_IN_MEMORY);
  localparam int unsigned IW = $clog2(VEC_BUFFER_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Latched transfer: result words, destination and index of the last word.
  // A length of 0 maps naturally to last index VEC_BUFFER_LEN-1 by wrap.
  typedef struct packed {
    logic [VEC_BUFFER_LEN-1:0][NUM_SIZE-1:0] data;
    logic [AW-1:0]                           dest;
    logic [IW-1:0]                           last;
  } xfer_t;

  state_t  state_q, state_d;
  logic    req_q;
  xfer_t   xfer_q, xfer_d;
  logic [IW-1:0] k_q, k_d;
  logic    busy_q, done_q, host_ready_q;
  logic [WORDS_IN_MEMORY-1:0][NUM_SIZE-1:0] mem_q;

  logic          start_c;
  xfer_t         new_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [NUM_SIZE-1:0] wr_data_c;

`ifdef VEC_WRITEBACK_PENDING_EN
  logic  pend_vld_q, pend_vld_d;
  xfer_t pend_q, pend_d;
`endif

  // Rising edge of the level copy flag is the only thing that starts a transfer.
  assign start_c = copy_req && !req_q;

  // Snapshot candidate built straight from the vector-unit outputs.
  assign new_c = '{data: flat_vec_buffer,
                   dest: dest,
                   last: IW'(length - IW'(1))};

  assign flat_memory = mem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign host_ready  = host_ready_q;

  // Next-state, sequencer bookkeeping and the single memory write port.
  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    k_d       = k_q;
    wr_en_c   = 1'b0;
    wr_addr_c = host_addr;
    wr_data_c = host_data;
`ifdef VEC_WRITEBACK_PENDING_EN
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Host owns the write port only while the sequencer is idle.
        if (host_we && host_ready_q) begin
          wr_en_c = 1'b1;
        end
        if (start_c) begin
          xfer_d  = new_c;
          k_d     = '0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = xfer_q.dest + AW'(k_q);
        wr_data_c = xfer_q.data[k_q];
        k_d       = IW'(k_q + IW'(1));
        if (k_q == xfer_q.last) begin
          state_d = S_DONE;
        end
`ifdef VEC_WRITEBACK_PENDING_EN
        if (start_c) begin
          pend_vld_d = 1'b1;
          pend_d     = new_c;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
`ifdef VEC_WRITEBACK_PENDING_EN
        // A request arriving now is newer than any stored one, so it wins.
        if (start_c) begin
          xfer_d     = new_c;
          k_d        = '0;
          pend_vld_d = 1'b0;
          state_d    = S_WRITE;
        end else if (pend_vld_q) begin
          xfer_d     = pend_q;
          k_d        = '0;
          pend_vld_d = 1'b0;
          state_d    = S_WRITE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, snapshot and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      xfer_q       <= '0;
      k_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      host_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= copy_req;
      xfer_q       <= xfer_d;
      k_q          <= k_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      host_ready_q <= (state_d == S_IDLE);
    end
  end

`ifdef VEC_WRITEBACK_PENDING_EN
  // One-deep pending request storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end
`endif

  // Working memory; writes are visible on flat_memory right after the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_addr_c] <= wr_data_c;
    end
  end

endmodule

// File: tb/tb_vec_writeback.sv
// Directed self-checking bench for vec_writeback.
module tb_vec_writeback;

`ifdef VEC_WRITEBACK_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [7:0][15:0] vbuf;
  logic             copy_req;
  logic [4:0]       dest;
  logic [2:0]       length;
  logic             host_we;
  logic [4:0]       host_addr;
  logic [15:0]      host_data;
  logic             host_ready;
  logic [31:0][15:0] mem_obs;
  logic             busy;
  logic             done;

  logic [31:0][15:0] exp_mem;
  int n_tests;
  int n_fail;

  vec_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .flat_vec_buffer (vbuf),
    .copy_req        (copy_req),
    .dest            (dest),
    .length          (length),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_ready      (host_ready),
    .flat_memory     (mem_obs),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    exp_mem = '0;
    n_tests++;
    if (mem_obs !== exp_mem) begin
      n_fail++; $display("FAIL reset_mem got %h exp %h", mem_obs, exp_mem);
    end
    n_tests++;
    if ({busy, done, host_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_flags got busy/done/ready=%b exp 001", {busy, done, host_ready});
    end
    rst = 1'b0;
    tick();
    host_we = 1'b1; host_addr = 5'd3; host_data = 16'h0005;
    tick();
    host_we = 1'b0;
    exp_mem[3] = 16'h0005;
    n_tests++;
    if (mem_obs !== exp_mem) begin
      n_fail++; $display("FAIL reset_load got %h exp %h", mem_obs, exp_mem);
    end
  endtask

  task automatic test_basic;
    for (int j = 0; j < 8; j++) vbuf[j] = 16'(j + 1);
    dest = 5'd4; length = 3'd3; copy_req = 1'b1;
    tick();
    n_tests++;
    if ({busy, done, host_ready} !== 3'b100 || mem_obs !== exp_mem) begin
      n_fail++; $display("FAIL basic_start got busy/done/ready=%b exp 100", {busy, done, host_ready});
    end
    vbuf = {8{16'hDEAD}};
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 3) exp_mem[4 + c - 1] = 16'(c);
      n_tests++;
      if (mem_obs !== exp_mem) begin
        n_fail++; $display("FAIL basic_mem c=%0d got %h exp %h", c, mem_obs, exp_mem);
      end
      n_tests++;
      if (done !== (c == 3) || busy !== (c <= 3)) begin
        n_fail++; $display("FAIL basic_flags c=%0d got done=%b busy=%b exp done=%b busy=%b",
                           c, done, busy, (c == 3), (c <= 3));
      end
    end
    copy_req = 1'b0;
    tick();
  endtask

  task automatic test_wrap;
    for (int j = 0; j < 8; j++) vbuf[j] = 16'h0100 + 16'(j);
    dest = 5'd30; length = 3'd0; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    vbuf = {8{16'hFFFF}};
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 8) exp_mem[(30 + c - 1) % 32] = 16'h0100 + 16'(c - 1);
      n_tests++;
      if (mem_obs !== exp_mem) begin
        n_fail++; $display("FAIL wrap_mem c=%0d got %h exp %h", c, mem_obs, exp_mem);
      end
      n_tests++;
      if (done !== (c == 8) || busy !== (c <= 8)) begin
        n_fail++; $display("FAIL wrap_flags c=%0d got done=%b busy=%b exp done=%b busy=%b",
                           c, done, busy, (c == 8), (c <= 8));
      end
    end
  endtask

  task automatic test_host_blocked;
    for (int j = 0; j < 8; j++) vbuf[j] = 16'h0A00 + 16'(j);
    dest = 5'd20; length = 3'd2; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    host_we = 1'b1; host_addr = 5'd10; host_data = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c <= 2) exp_mem[20 + c - 1] = 16'h0A00 + 16'(c - 1);
      n_tests++;
      if (host_ready !== (c == 3)) begin
        n_fail++; $display("FAIL host_ready c=%0d got %b exp %b", c, host_ready, (c == 3));
      end
      n_tests++;
      if (mem_obs !== exp_mem) begin
        n_fail++; $display("FAIL host_blocked_mem c=%0d got %h exp %h", c, mem_obs, exp_mem);
      end
    end
    host_we = 1'b0;
    tick();
    n_tests++;
    if (mem_obs[10] !== exp_mem[10]) begin
      n_fail++; $display("FAIL host_blocked_addr10 got %h exp %h", mem_obs[10], exp_mem[10]);
    end
  endtask

  task automatic test_back_to_back;
    bit exp_done, exp_busy;
    for (int j = 0; j < 8; j++) vbuf[j] = 16'h0B00 + 16'(j);
    dest = 5'd8; length = 3'd4; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 4) exp_mem[8 + c - 1] = 16'h0B00 + 16'(c - 1);
      if (PEND && c == 6) exp_mem[16] = 16'h0C00;
      if (PEND && c == 7) exp_mem[17] = 16'h0C01;
      exp_done = (c == 4) || (PEND && c == 7);
      exp_busy = PEND ? (c <= 7) : (c <= 4);
      n_tests++;
      if (mem_obs !== exp_mem) begin
        n_fail++; $display("FAIL b2b_mem c=%0d got %h exp %h", c, mem_obs, exp_mem);
      end
      n_tests++;
      if (done !== exp_done || busy !== exp_busy) begin
        n_fail++; $display("FAIL b2b_flags c=%0d got done=%b busy=%b exp done=%b busy=%b",
                           c, done, busy, exp_done, exp_busy);
      end
      if (c == 1) begin
        for (int j = 0; j < 8; j++) vbuf[j] = 16'h0C00 + 16'(j);
        dest = 5'd16; length = 3'd2; copy_req = 1'b1;
      end
      if (c == 2) begin
        vbuf = {8{16'h5555}};
        dest = 5'd0; length = 3'd7;
      end
    end
    copy_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    for (int j = 0; j < 8; j++) vbuf[j] = 16'h0D00 + 16'(j);
    dest = 5'd0; length = 3'd5; copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    tick();
    tick();
    exp_mem[0] = 16'h0D00;
    exp_mem[1] = 16'h0D01;
    n_tests++;
    if (mem_obs !== exp_mem) begin
      n_fail++; $display("FAIL mid_pre got %h exp %h", mem_obs, exp_mem);
    end
    rst = 1'b1;
    #1;
    exp_mem = '0;
    n_tests++;
    if (mem_obs !== exp_mem) begin
      n_fail++; $display("FAIL mid_rst_mem got %h exp %h", mem_obs, exp_mem);
    end
    n_tests++;
    if ({busy, done, host_ready} !== 3'b001) begin
      n_fail++; $display("FAIL mid_rst_flags got busy/done/ready=%b exp 001", {busy, done, host_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (mem_obs !== exp_mem || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_abandon c=%0d got done=%b busy=%b mem %h", c, done, busy, mem_obs);
      end
    end
    // Start and host write in the same idle cycle.
    vbuf = '0; vbuf[0] = 16'h0077;
    dest = 5'd2; length = 3'd1; copy_req = 1'b1;
    host_we = 1'b1; host_addr = 5'd9; host_data = 16'h1234;
    tick();
    host_we = 1'b0; copy_req = 1'b0;
    exp_mem[9] = 16'h1234;
    n_tests++;
    if (mem_obs !== exp_mem || busy !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle got busy=%b mem %h exp busy=1 mem %h", busy, mem_obs, exp_mem);
    end
    tick();
    exp_mem[2] = 16'h0077;
    n_tests++;
    if (mem_obs !== exp_mem || done !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_xfer got done=%b mem %h exp done=1 mem %h", done, mem_obs, exp_mem);
    end
    tick();
    n_tests++;
    if ({busy, done, host_ready} !== 3'b001) begin
      n_fail++; $display("FAIL post_rst_idle got busy/done/ready=%b exp 001", {busy, done, host_ready});
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; vbuf = '0; copy_req = 1'b0; dest = '0; length = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    exp_mem = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_host_blocked();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
